phase_seq_sched: RTL and testbench

Scheduler and sequencer for the shared two-phase ramp-counter datapath. It arbitrates round-robin between two requesters and seeds the counter with the winner's 8-bit value. It then runs phase 1 (step +STEP1 until cnt > TH1) and phase 2 (step +STEP2 until cnt > TH2). It returns cnt − OFFS to the owner over a valid/ready result port. It sits between the request sources and the downstream consumer of OUT.

---
 rtl/phase_seq_pkg.sv | 21 ++
 rtl/phase_seq_sched_rr_arb2.sv | 22 ++
 rtl/phase_seq_sched.sv | 160 ++++++++++++++++
 tb/tb_phase_seq_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/phase_seq_pkg.sv
// Shared types and default constants for the two-phase ramp sequencer.
// Latency: none (declarations only). Backpressure: not applicable.
// Build option: PHASE_SEQ_TIMEOUT_EN enables the per-phase timeout abort.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int W_DEF     = 8;
    localparam int TH1_DEF   = 7;
    localparam int TH2_DEF   = 20;
    localparam int STEP1_DEF = 1;
    localparam int STEP2_DEF = 2;
    localparam int OFFS_DEF  = 8;
    localparam int TMO_DEF   = 64;

endpackage

// File: rtl/phase_seq_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the preferred requester.
// Latency: combinational, grant in the same cycle as the request.
// Backpressure: grants only while en is high; pointer update is the parent's job.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[ptr]) begin
                gnt[ptr] = 1'b1;
            end else if (req[~ptr]) begin
                gnt[~ptr] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phase_seq_sched.sv
// Round-robin scheduler driving a two-phase ramp counter; returns cnt-OFFS to the owner.
// Latency: grant in IDLE, result valid 3+ cycles later depending on the seed.
// Backpressure: result held in DONE until OREADY; new requests wait. Option: PHASE_SEQ_TIMEOUT_EN.
module phase_seq_sched
    import phase_seq_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int TH1   = TH1_DEF,
    parameter int TH2   = TH2_DEF,
    parameter int STEP1 = STEP1_DEF,
    parameter int STEP2 = STEP2_DEF,
    parameter int OFFS  = OFFS_DEF,
    parameter int TMO   = TMO_DEF
) (
    input  logic         CLK,
    input  logic         RSTX,
    input  logic [1:0]   REQ,
    input  logic [W-1:0] IN0,
    input  logic [W-1:0] IN1,
    output logic [1:0]   GNT,
    output logic         BUSY,
    output logic [W-1:0] OUT,
    output logic         OID,
    output logic         OERR,
    output logic         OVALID,
    input  logic         OREADY
);

    localparam logic [W-1:0] TH1_V   = W'(TH1);
    localparam logic [W-1:0] TH2_V   = W'(TH2);
    localparam logic [W-1:0] STEP1_V = W'(STEP1);
    localparam logic [W-1:0] STEP2_V = W'(STEP2);
    localparam logic [W-1:0] OFFS_V  = W'(OFFS);

    state_t       state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic [W-1:0] out_r, out_nxt;
    logic         owner, owner_nxt;
    logic         rr_ptr, rr_nxt;
    logic         arb_en;

    // Gating with RSTX keeps GNT at 00 while reset is held, even with REQ high.
    assign arb_en = (state == IDLE) && RSTX;

    rr_arb2 u_arb (
        .req (REQ),
        .ptr (rr_ptr),
        .en  (arb_en),
        .gnt (GNT)
    );

`ifdef PHASE_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_V = TW'(TMO);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          oerr_r, oerr_nxt;

    assign tmo_hit = (tmo_cnt == TMO_V);

    // Cleared on any state change, so it restarts at entry to PH1 and to PH2.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            tmo_cnt <= '0;
            oerr_r  <= 1'b0;
        end else begin
            oerr_r <= oerr_nxt;
            if (state_nxt != state || state == IDLE || state == DONE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign OERR = oerr_r;
`else
    assign OERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state  <= IDLE;
            cnt    <= '0;
            out_r  <= '0;
            owner  <= 1'b0;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            out_r  <= out_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = out_r;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
`ifdef PHASE_SEQ_TIMEOUT_EN
        oerr_nxt  = oerr_r;
`endif
        case (state)
            IDLE: begin
                if (GNT != 2'b00) begin
                    cnt_nxt   = GNT[1] ? IN1 : IN0;
                    owner_nxt = GNT[1];
                    state_nxt = PH1;
                end
            end
            PH1: begin
                if (cnt > TH1_V) begin
                    state_nxt = PH2;
`ifdef PHASE_SEQ_TIMEOUT_EN
                end else if (tmo_hit) begin
                    out_nxt   = cnt;
                    oerr_nxt  = 1'b1;
                    state_nxt = DONE;
`endif
                end else begin
                    cnt_nxt = cnt + STEP1_V;
                end
            end
            PH2: begin
                if (cnt > TH2_V) begin
                    out_nxt   = cnt - OFFS_V;
`ifdef PHASE_SEQ_TIMEOUT_EN
                    oerr_nxt  = 1'b0;
`endif
                    state_nxt = DONE;
`ifdef PHASE_SEQ_TIMEOUT_EN
                end else if (tmo_hit) begin
                    out_nxt   = cnt;
                    oerr_nxt  = 1'b1;
                    state_nxt = DONE;
`endif
                end else begin
                    cnt_nxt = cnt + STEP2_V;
                end
            end
            DONE: begin
                if (OREADY) begin
                    state_nxt = IDLE;
                    rr_nxt    = ~owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign BUSY   = (state != IDLE);
    assign OVALID = (state == DONE);
    assign OUT    = out_r;
    assign OID    = owner;

endmodule

// File: tb/tb_phase_seq_sched.sv
// Self-checking bench for phase_seq_sched: scoreboard of expected results per grant.
// A second instance with an unreachable TH2 exercises PHASE_SEQ_TIMEOUT_EN behaviour.
module tb_phase_seq_sched;

    logic       CLK = 1'b0;
    logic       RSTX;
    logic [1:0] REQ;
    logic [7:0] IN0, IN1;
    logic [1:0] GNT;
    logic       BUSY, OID, OERR, OVALID, OREADY;
    logic [7:0] OUT;

    logic       rstx_t;
    logic [1:0] req_t;
    logic [7:0] in0_t, in1_t, out_t;
    logic [1:0] gnt_t;
    logic       busy_t, oid_t, oerr_t, ovalid_t, oready_t;

    always #5 CLK = ~CLK;

    phase_seq_sched dut (
        .CLK(CLK), .RSTX(RSTX), .REQ(REQ), .IN0(IN0), .IN1(IN1),
        .GNT(GNT), .BUSY(BUSY), .OUT(OUT), .OID(OID), .OERR(OERR),
        .OVALID(OVALID), .OREADY(OREADY)
    );

    phase_seq_sched #(.TH2(255), .TMO(16)) dut_tmo (
        .CLK(CLK), .RSTX(rstx_t), .REQ(req_t), .IN0(in0_t), .IN1(in1_t),
        .GNT(gnt_t), .BUSY(busy_t), .OUT(out_t), .OID(oid_t), .OERR(oerr_t),
        .OVALID(ovalid_t), .OREADY(oready_t)
    );

    typedef struct {
        logic [7:0] out;
        logic       oid;
        logic       oerr;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference behaviour with default parameters: cycles from grant to OVALID.
    function automatic exp_t model(input logic [7:0] seed, input logic id);
        exp_t       e;
        logic [7:0] c;
        int         t;
        c = seed;
        t = 1;
        while (!(c > 8'd7)) begin c = c + 8'd1; t++; end
        t++;
        while (!(c > 8'd20)) begin c = c + 8'd2; t++; end
        t++;
        e.out  = c - 8'd8;
        e.oid  = id;
        e.oerr = 1'b0;
        e.lat  = t;
        return e;
    endfunction

    task automatic run_one(input logic id, input logic [7:0] seed, input int hold);
        exp_t       e;
        int         lat;
        logic [7:0] snap;
        @(negedge CLK);
        if (id) IN1 = seed; else IN0 = seed;
        REQ[id] = 1'b1;
        #1 chk("gnt", {30'd0, GNT}, id ? 32'd2 : 32'd1);
        sb.push_back(model(seed, id));
        @(posedge CLK);
        #1 REQ[id] = 1'b0;
        @(negedge CLK);
        lat = 1;
        while (!OVALID && lat < 200) begin
            @(negedge CLK);
            lat++;
        end
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("out", {24'd0, OUT}, {24'd0, e.out});
        chk("oid", {31'd0, OID}, {31'd0, e.oid});
        chk("oerr", {31'd0, OERR}, {31'd0, e.oerr});
        snap = OUT;
        for (int k = 0; k < hold; k++) begin
            @(negedge CLK);
            chk("hold_ovalid", {31'd0, OVALID}, 32'd1);
            chk("hold_out", {24'd0, OUT}, {24'd0, snap});
            chk("hold_oid", {31'd0, OID}, {31'd0, id});
        end
        OREADY = 1'b1;
        @(posedge CLK);
        #1 OREADY = 1'b0;
        @(negedge CLK);
        chk("post_ovalid", {31'd0, OVALID}, 32'd0);
        chk("post_busy", {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        exp_t e;
        int   ng, cyc, lat;
        int   gcyc[3];
        logic flag;

        RSTX = 1'b0; rstx_t = 1'b0;
        REQ = 2'b00; IN0 = 8'd0; IN1 = 8'd0; OREADY = 1'b0;
        req_t = 2'b00; in0_t = 8'd0; in1_t = 8'd0; oready_t = 1'b1;
        #23;
        chk("rst_gnt", {30'd0, GNT}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_ovalid", {31'd0, OVALID}, 32'd0);
        chk("rst_out", {24'd0, OUT}, 32'd0);
        chk("rst_oid", {31'd0, OID}, 32'd0);
        chk("rst_oerr", {31'd0, OERR}, 32'd0);
        @(negedge CLK);
        RSTX = 1'b1; rstx_t = 1'b1;

        run_one(1'b0, 8'd0, 0);
        run_one(1'b1, 8'd100, 0);
        run_one(1'b0, 8'd50, 5);
        run_one(1'b1, 8'd7, 0);
        run_one(1'b0, 8'd8, 0);
        run_one(1'b1, 8'd20, 2);
        run_one(1'b0, 8'd21, 0);
        run_one(1'b1, 8'd255, 0);

        // Asynchronous reset in the middle of PH2.
        @(negedge CLK);
        IN0 = 8'd0; REQ[0] = 1'b1;
        @(posedge CLK);
        #1 REQ[0] = 1'b0;
        repeat (12) @(negedge CLK);
        chk("ph2_busy", {31'd0, BUSY}, 32'd1);
        #2 RSTX = 1'b0;
        #1;
        chk("arst_busy", {31'd0, BUSY}, 32'd0);
        chk("arst_ovalid", {31'd0, OVALID}, 32'd0);
        chk("arst_out", {24'd0, OUT}, 32'd0);
        chk("arst_oid", {31'd0, OID}, 32'd0);
        chk("arst_gnt", {30'd0, GNT}, 32'd0);
        @(negedge CLK);
        RSTX = 1'b1;
        @(negedge CLK);
        chk("rel_busy", {31'd0, BUSY}, 32'd0);
        chk("rel_ovalid", {31'd0, OVALID}, 32'd0);

        // Both requesting with OREADY high: grants alternate 0,1,0.
        IN0 = 8'd30; IN1 = 8'd40; OREADY = 1'b1; REQ = 2'b11;
        #1;
        ng = 0;
        cyc = 0;
        while (ng < 3 && cyc < 100) begin
            if (GNT != 2'b00) begin
                chk("arb_gnt", {30'd0, GNT}, ng[0] ? 32'd2 : 32'd1);
                gcyc[ng] = cyc;
                sb.push_back(model(ng[0] ? IN1 : IN0, ng[0]));
                ng++;
            end
            if (OVALID) begin
                e = sb.pop_front();
                chk("arb_out", {24'd0, OUT}, {24'd0, e.out});
                chk("arb_oid", {31'd0, OID}, {31'd0, e.oid});
            end
            @(negedge CLK);
            cyc++;
        end
        REQ = 2'b00;
        chk("arb_grants", ng, 3);
        chk("arb_gap1", gcyc[1] - gcyc[0], 4);
        chk("arb_gap2", gcyc[2] - gcyc[1], 4);
        lat = 0;
        while (!OVALID && lat < 100) begin @(negedge CLK); lat++; end
        e = sb.pop_front();
        chk("arb_out3", {24'd0, OUT}, {24'd0, e.out});
        chk("arb_oid3", {31'd0, OID}, {31'd0, e.oid});
        @(negedge CLK);
        OREADY = 1'b0;

        // Unreachable TH2 on the second instance.
        @(negedge CLK);
        req_t = 2'b01; in0_t = 8'd0;
        @(posedge CLK);
        #1 req_t = 2'b00;
        @(negedge CLK);
`ifdef PHASE_SEQ_TIMEOUT_EN
        lat = 1;
        while (!ovalid_t && lat < 200) begin @(negedge CLK); lat++; end
        chk("tmo_latency", lat, 27);
        chk("tmo_out", {24'd0, out_t}, 32'd40);
        chk("tmo_oerr", {31'd0, oerr_t}, 32'd1);
        chk("tmo_oid", {31'd0, oid_t}, 32'd0);
`else
        flag = 1'b1;
        repeat (300) begin
            if (!busy_t || ovalid_t) flag = 1'b0;
            @(negedge CLK);
        end
        chk("notmo_busy_forever", {31'd0, flag}, 32'd1);
        chk("notmo_oerr", {31'd0, oerr_t}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
